// File: rtl/pc_redirect_sequencer_pkg.sv
// rtl/pc_redirect_sequencer_pkg.sv - shared state enum, widths and vector defaults for the PC redirect sequencer
package pc_redirect_sequencer_pkg;

    localparam int MWORD_SIZE_DEF        = 32;
    localparam int SMALL_NUMBER_SIZE_DEF = 8;
    localparam int ALIGN_BITS_DEF        = 2;

    localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
    localparam logic [31:0] INT_BASE_DEF      = 32'h0000_0100;
    localparam logic [31:0] EXC_BASE_DEF      = 32'h0000_0200;
    localparam logic [7:0]  MISALIGN_CODE_DEF = 8'h01;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        IN_HANDLER = 2'd2,
        HALTED     = 2'd3
    } seqState_t;

endpackage

// File: rtl/pc_redirect_sequencer_mux.sv
// rtl/pc_redirect_sequencer_mux.sv - pc_next_mux: priority source select and next-PC formation
// Optional alignment check on target/result redirects when PC_ALIGN_CHECK_EN is defined.
module pc_next_mux
    import pc_redirect_sequencer_pkg::*;
#(
    parameter int                       MWORD_SIZE        = MWORD_SIZE_DEF,
    parameter int                       SMALL_NUMBER_SIZE = SMALL_NUMBER_SIZE_DEF,
    parameter int                       ALIGN_BITS        = ALIGN_BITS_DEF,
    parameter logic [MWORD_SIZE-1:0]    INT_BASE          = INT_BASE_DEF,
    parameter logic [MWORD_SIZE-1:0]    EXC_BASE          = EXC_BASE_DEF,
    parameter logic [SMALL_NUMBER_SIZE-1:0] MISALIGN_CODE = MISALIGN_CODE_DEF
) (
    input  logic                         active,
    input  logic                         intEnable,
    input  logic                         excValid,
    input  logic [SMALL_NUMBER_SIZE-1:0] excCode,
    input  logic                         intValid,
    input  logic [SMALL_NUMBER_SIZE-1:0] intCode,
    input  logic                         targetValid,
    input  logic [MWORD_SIZE-1:0]        insTarget,
    input  logic                         resultValid,
    input  logic [MWORD_SIZE-1:0]        insResult,
    input  logic                         fetchReady,
    input  logic [MWORD_SIZE-1:0]        pc,
    output logic                         selectExc,
    output logic                         selectInt,
    output logic                         selectTarget,
    output logic                         selectResult,
    output logic                         selectMoved,
    output logic [MWORD_SIZE-1:0]        nextPc
);

    localparam logic [MWORD_SIZE-1:0] STEP = {{(MWORD_SIZE-1){1'b0}}, 1'b1} << ALIGN_BITS;

    logic targetBad;
    logic resultBad;

`ifdef PC_ALIGN_CHECK_EN
    assign targetBad = |insTarget[ALIGN_BITS-1:0];
    assign resultBad = |insResult[ALIGN_BITS-1:0];
`else
    assign targetBad = 1'b0;
    assign resultBad = 1'b0;
`endif

    // A misaligned redirect turns into an exception carrying MISALIGN_CODE.
    always_comb begin
        selectExc    = 1'b0;
        selectInt    = 1'b0;
        selectTarget = 1'b0;
        selectResult = 1'b0;
        selectMoved  = 1'b0;
        nextPc       = pc;
        if (active) begin
            if (excValid) begin
                selectExc = 1'b1;
                nextPc    = {EXC_BASE[MWORD_SIZE-1:SMALL_NUMBER_SIZE], excCode};
            end else if (intValid && intEnable) begin
                selectInt = 1'b1;
                nextPc    = {INT_BASE[MWORD_SIZE-1:SMALL_NUMBER_SIZE], intCode};
            end else if (targetValid) begin
                if (targetBad) begin
                    selectExc = 1'b1;
                    nextPc    = {EXC_BASE[MWORD_SIZE-1:SMALL_NUMBER_SIZE], MISALIGN_CODE};
                end else begin
                    selectTarget = 1'b1;
                    nextPc       = insTarget;
                end
            end else if (resultValid) begin
                if (resultBad) begin
                    selectExc = 1'b1;
                    nextPc    = {EXC_BASE[MWORD_SIZE-1:SMALL_NUMBER_SIZE], MISALIGN_CODE};
                end else begin
                    selectResult = 1'b1;
                    nextPc       = insResult;
                end
            end else if (fetchReady) begin
                selectMoved = 1'b1;
                nextPc      = pc + STEP;
            end
        end
    end

endmodule

// File: rtl/pc_redirect_sequencer.sv
// rtl/pc_redirect_sequencer.sv - fetch PC owner: redirect arbitration, handler nesting, fetch hold
// Define PC_ALIGN_CHECK_EN to fault misaligned target/result redirects.
module pc_redirect_sequencer
    import pc_redirect_sequencer_pkg::*;
#(
    parameter int                           MWORD_SIZE        = MWORD_SIZE_DEF,
    parameter int                           SMALL_NUMBER_SIZE = SMALL_NUMBER_SIZE_DEF,
    parameter int                           ALIGN_BITS        = ALIGN_BITS_DEF,
    parameter logic [MWORD_SIZE-1:0]        RESET_PC          = RESET_PC_DEF,
    parameter logic [MWORD_SIZE-1:0]        INT_BASE          = INT_BASE_DEF,
    parameter logic [MWORD_SIZE-1:0]        EXC_BASE          = EXC_BASE_DEF,
    parameter logic [SMALL_NUMBER_SIZE-1:0] MISALIGN_CODE     = MISALIGN_CODE_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         intReq,
    input  logic [SMALL_NUMBER_SIZE-1:0] intCode,
    input  logic                         excReq,
    input  logic [SMALL_NUMBER_SIZE-1:0] excCode,
    input  logic                         targetValid,
    input  logic [MWORD_SIZE-1:0]        insTarget,
    input  logic                         resultValid,
    input  logic [MWORD_SIZE-1:0]        insResult,
    input  logic                         retReq,
    input  logic                         fetchReady,
    output logic [MWORD_SIZE-1:0]        pc,
    output logic                         pcValid,
    output logic                         selectInt,
    output logic                         selectExc,
    output logic                         selectTarget,
    output logic                         selectResult,
    output logic                         selectMoved,
    output logic                         intAck,
    output logic                         excAck,
    output logic                         inHandler,
    output logic                         halted
);

    seqState_t state, stateNext;

    logic                         intPending, excPending;
    logic [SMALL_NUMBER_SIZE-1:0] intCodeQ, excCodeQ;
    logic                         intEff, excEff;
    logic [SMALL_NUMBER_SIZE-1:0] intCodeEff, excCodeEff;
    logic                         muxExc, muxInt, muxTarget, muxResult, muxMoved;
    logic [MWORD_SIZE-1:0]        muxPc, pcNext;

    // Requests arriving this cycle compete immediately alongside latched ones.
    assign intEff     = intPending | intReq;
    assign intCodeEff = intPending ? intCodeQ : intCode;
    assign excEff     = excPending | excReq;
    assign excCodeEff = excReq ? excCode : excCodeQ;

    pc_next_mux #(
        .MWORD_SIZE        (MWORD_SIZE),
        .SMALL_NUMBER_SIZE (SMALL_NUMBER_SIZE),
        .ALIGN_BITS        (ALIGN_BITS),
        .INT_BASE          (INT_BASE),
        .EXC_BASE          (EXC_BASE),
        .MISALIGN_CODE     (MISALIGN_CODE)
    ) u_mux (
        .active       (state == RUN || state == IN_HANDLER),
        .intEnable    (state == RUN),
        .excValid     (excEff),
        .excCode      (excCodeEff),
        .intValid     (intEff),
        .intCode      (intCodeEff),
        .targetValid  (targetValid),
        .insTarget    (insTarget),
        .resultValid  (resultValid),
        .insResult    (insResult),
        .fetchReady   (fetchReady),
        .pc           (pc),
        .selectExc    (muxExc),
        .selectInt    (muxInt),
        .selectTarget (muxTarget),
        .selectResult (muxResult),
        .selectMoved  (muxMoved),
        .nextPc       (muxPc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        pcNext       = muxPc;
        selectExc    = muxExc;
        selectInt    = muxInt;
        selectTarget = muxTarget;
        selectResult = muxResult;
        selectMoved  = muxMoved;
        intAck       = muxInt;
        excAck       = muxExc;
        case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (muxExc || muxInt) stateNext = IN_HANDLER;
            end
            IN_HANDLER: begin
                // Exception inside a handler: acknowledge, but freeze the PC and stop.
                if (muxExc) begin
                    selectExc = 1'b0;
                    pcNext    = pc;
                    stateNext = HALTED;
                end else if (muxResult && retReq) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            intPending <= 1'b0;
            intCodeQ   <= '0;
            excPending <= 1'b0;
            excCodeQ   <= '0;
        end else begin
            pc         <= pcNext;
            intPending <= intEff && !muxInt;
            excPending <= excEff && !(muxExc && excEff);
            if (intReq && !intPending) intCodeQ <= intCode;
            if (excReq) excCodeQ <= excCode;
        end
    end

    assign pcValid   = (state == RUN) || (state == IN_HANDLER);
    assign inHandler = (state == IN_HANDLER);
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// tb/tb_pc_redirect_sequencer.sv - directed self-checking bench for pc_redirect_sequencer
module tb_pc_redirect_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        intReq, excReq, targetValid, resultValid, retReq, fetchReady;
    logic [7:0]  intCode, excCode;
    logic [31:0] insTarget, insResult;
    logic [31:0] pc;
    logic        pcValid, selectInt, selectExc, selectTarget, selectResult, selectMoved;
    logic        intAck, excAck, inHandler, halted;

    int totalCnt = 0;
    int badCnt   = 0;

    pc_redirect_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .intReq       (intReq),
        .intCode      (intCode),
        .excReq       (excReq),
        .excCode      (excCode),
        .targetValid  (targetValid),
        .insTarget    (insTarget),
        .resultValid  (resultValid),
        .insResult    (insResult),
        .retReq       (retReq),
        .fetchReady   (fetchReady),
        .pc           (pc),
        .pcValid      (pcValid),
        .selectInt    (selectInt),
        .selectExc    (selectExc),
        .selectTarget (selectTarget),
        .selectResult (selectResult),
        .selectMoved  (selectMoved),
        .intAck       (intAck),
        .excAck       (excAck),
        .inHandler    (inHandler),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Select vector order: {exc, int, target, result, moved}
    task automatic checkSel(input string tag, input logic [4:0] exp);
        check(tag, 32'({selectExc, selectInt, selectTarget, selectResult, selectMoved}), 32'(exp));
    endtask

    task automatic idle();
        intReq = 1'b0; intCode = 8'h00;
        excReq = 1'b0; excCode = 8'h00;
        targetValid = 1'b0; insTarget = 32'h0;
        resultValid = 1'b0; insResult = 32'h0;
        retReq = 1'b0; fetchReady = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_pcValid", 32'(pcValid), 0);
        checkSel("rst_sel", 5'b00000);
        check("rst_acks", 32'({intAck, excAck}), 0);
        check("rst_flags", 32'({inHandler, halted}), 0);

        reset = 1'b0;
        #1;
        check("boot_pcValid", 32'(pcValid), 0);
        checkSel("boot_sel", 5'b00000);

        step();
        check("run0_pcValid", 32'(pcValid), 1);
        check("run0_pc", pc, 32'h0);
        checkSel("run0_sel", 5'b00001);
        step();
        check("run1_pc", pc, 32'h4);
        step();
        check("run2_pc", pc, 32'h8);

        fetchReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_pc", pc, 32'h8);
            checkSel("hold_sel", 5'b00000);
            step();
        end
        fetchReady = 1'b1;
        #1;
        checkSel("resume_sel", 5'b00001);
        step();
        check("resume_pc", pc, 32'hC);

        intReq = 1'b1; intCode = 8'h05;
        targetValid = 1'b1; insTarget = 32'h80;
        #1;
        checkSel("int_sel", 5'b01000);
        check("int_ack", 32'(intAck), 1);
        step();
        idle();
        #1;
        check("int_pc", pc, 32'h105);
        check("int_inHandler", 32'(inHandler), 1);
        check("int_ack_pulse", 32'(intAck), 0);

        intReq = 1'b1; intCode = 8'h07;
        #1;
        checkSel("masked_sel", 5'b00001);
        check("masked_ack", 32'(intAck), 0);
        step();
        idle();
        #1;
        check("masked_pc", pc, 32'h109);

        resultValid = 1'b1; retReq = 1'b1; insResult = 32'h40;
        #1;
        checkSel("ret_sel", 5'b00010);
        step();
        idle();
        #1;
        check("ret_pc", pc, 32'h40);
        check("ret_inHandler", 32'(inHandler), 0);
        checkSel("pend_int_sel", 5'b01000);
        check("pend_int_ack", 32'(intAck), 1);
        step();
        check("pend_int_pc", pc, 32'h107);
        check("pend_int_inHandler", 32'(inHandler), 1);

        resultValid = 1'b1; retReq = 1'b1; insResult = 32'h100;
        step();
        idle();
        #1;
        check("ret2_pc", pc, 32'h100);
        check("ret2_inHandler", 32'(inHandler), 0);

        excReq = 1'b1; excCode = 8'h03;
        #1;
        checkSel("exc_sel", 5'b10000);
        check("exc_ack", 32'(excAck), 1);
        step();
        idle();
        #1;
        check("exc_pc", pc, 32'h203);
        check("exc_inHandler", 32'(inHandler), 1);

        excReq = 1'b1; excCode = 8'h09;
        #1;
        checkSel("dbl_sel", 5'b00000);
        check("dbl_ack", 32'(excAck), 1);
        step();
        idle();
        #1;
        check("halt_flag", 32'(halted), 1);
        check("halt_pcValid", 32'(pcValid), 0);
        check("halt_pc", pc, 32'h203);
        checkSel("halt_sel", 5'b00000);
        step();
        check("halt_stay", 32'(halted), 1);

        reset = 1'b1;
        #1;
        check("rst2_pc", pc, 32'h0);
        check("rst2_halted", 32'(halted), 0);
        step();
        reset = 1'b0;
        step();
        check("rst2_run_pc", pc, 32'h0);

        targetValid = 1'b1; insTarget = 32'hFFFF_FFFC;
        resultValid = 1'b1; insResult = 32'h300;
        #1;
        checkSel("tgt_vs_res_sel", 5'b00100);
        step();
        idle();
        #1;
        check("tgt_pc", pc, 32'hFFFF_FFFC);
        checkSel("wrap_sel", 5'b00001);
        step();
        check("wrap_pc", pc, 32'h0);

        resultValid = 1'b1; retReq = 1'b1; insResult = 32'h50;
        #1;
        checkSel("plain_ret_sel", 5'b00010);
        step();
        idle();
        #1;
        check("plain_ret_pc", pc, 32'h50);
        check("plain_ret_inHandler", 32'(inHandler), 0);

        targetValid = 1'b1; insTarget = 32'h42;
        #1;
`ifdef PC_ALIGN_CHECK_EN
        checkSel("misalign_sel", 5'b10000);
        check("misalign_ack", 32'(excAck), 1);
        step();
        idle();
        #1;
        check("misalign_pc", pc, 32'h201);
        check("misalign_inHandler", 32'(inHandler), 1);
`else
        checkSel("unaligned_sel", 5'b00100);
        check("unaligned_ack", 32'(excAck), 0);
        step();
        idle();
        #1;
        check("unaligned_pc", pc, 32'h42);
        check("unaligned_inHandler", 32'(inHandler), 0);
`endif

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
Sequential controller that owns the fetch program counter and drives the PC-select datapath.
- Arbitrates between interrupt, exception, branch-target and register-result redirects, with sequential increment as the fallback.
- Tracks handler nesting (interrupt masking, double-fault halt) and holds the PC while fetch back-pressures.
- Sits between the front-end fetch stage and the commit/execute redirect sources.

Parameters:
MWORD_SIZE, 32, machine word / PC width
SMALL_NUMBER_SIZE, 8, width of interrupt and exception codes
ALIGN_BITS, 2, instruction alignment; sequential increment = 1 << ALIGN_BITS
RESET_PC, 32'h0000_0000, PC presented after reset
INT_BASE, 32'h0000_0100, interrupt vector base; the upper MWORD_SIZE-SMALL_NUMBER_SIZE bits are used
EXC_BASE, 32'h0000_0200, exception vector base; the upper bits are used the same way
MISALIGN_CODE, 8'h01, exception code raised by the optional alignment check

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
intReq  in  1  interrupt request, level
intCode  in  SMALL_NUMBER_SIZE  interrupt code, sampled when intReq first seen
excReq  in  1  exception request, one-cycle pulse
excCode  in  SMALL_NUMBER_SIZE  exception code, valid with excReq
targetValid  in  1  branch redirect request
insTarget  in  MWORD_SIZE  branch target
resultValid  in  1  register-result redirect (jump-register / return)
insResult  in  MWORD_SIZE  redirect address
retReq  in  1  qualifies resultValid as return-from-handler
fetchReady  in  1  fetch stage accepts pc this cycle
pc  out  MWORD_SIZE  current fetch PC (registered)
pcValid  out  1  pc is meaningful
selectInt, selectExc, selectTarget, selectResult, selectMoved  out  1 each  one-hot-or-zero source decision this cycle (combinational from state + inputs)
intAck  out  1  one-cycle pulse when an interrupt is taken
excAck  out  1  one-cycle pulse when an exception is taken
inHandler  out  1  high while in IN_HANDLER state
halted  out  1  high in HALTED state

Behaviour:
- Reset values: pc=RESET_PC, pcValid=0, all selects 0, intAck=excAck=0, inHandler=0, halted=0, state=BOOT, pending latches cleared.
- Reset asserted mid-operation aborts everything immediately (async); pending requests are discarded.
- FSM states and transitions:
  - BOOT: exactly one cycle, then RUN with pcValid=1.
  - RUN: normal operation.
  - IN_HANDLER: interrupts masked.
  - HALTED: pcValid=0 and selects 0 until reset.
- Pending latches:
  - intPending is set on intReq when not already pending, capturing intCode.
  - excPending is set on an excReq pulse, capturing excCode. A new excReq in the same cycle as an older pending exception overwrites the code; the newest wins.
- Source priority each cycle in RUN/IN_HANDLER: excPending > intPending (RUN only) > targetValid > resultValid > moved.
- Redirects (exc/int/target/result) are taken regardless of fetchReady.
  - Next pc: int -> {INT_BASE[MW-1:SN], code}; exc -> {EXC_BASE[MW-1:SN], code}; target -> insTarget; result -> insResult.
  - Latency: 1 cycle from select to pc update.
- Moved: selectMoved=1 only if no redirect and fetchReady=1; pc <= pc + (1<<ALIGN_BITS), modulo 2^MWORD_SIZE (wraps, no flag).
- Hold: no redirect and fetchReady=0 -> all selects 0, pc holds.
- Taking an interrupt: intAck pulse, clear intPending, RUN->IN_HANDLER.
- Taking an exception: excAck pulse, clear excPending.
  - RUN -> IN_HANDLER.
  - IN_HANDLER -> HALTED (double fault); no select is asserted in that cycle.
- resultValid & retReq in IN_HANDLER -> selectResult, state -> RUN. retReq outside IN_HANDLER is a plain result redirect.
- Interrupt arriving while in IN_HANDLER stays pending and is taken on the first RUN cycle after return.
- Simultaneous target+result: target wins; the result request is dropped, not queued.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: a target or result redirect whose low ALIGN_BITS are non-zero is not taken. The cycle is converted into an exception with code MISALIGN_CODE (selectExc=1, excAck pulse, normal exception state transition).
- Not defined: addresses pass unchecked; low bits are forwarded as given.

Decomposition:
- Shared package: FSM state enum (BOOT, RUN, IN_HANDLER, HALTED), word/code width constants, vector base defaults, MISALIGN_CODE.
- One natural sub-module: pc_next_mux. It is a combinational priority select plus address formation, and its interface matches the existing PC-select datapath so it can be swapped in.

Test Plan:
- Reset release, fetchReady=1 for 4 cycles -> pcValid from cycle 1; pc = 0x0, 0x4, 0x8, 0xC; selectMoved=1 each cycle.
- fetchReady=0 for 3 cycles at pc=0x8 -> pc holds 0x8, all selects 0; resumes to 0xC.
- intReq with intCode=0x05 and targetValid in the same cycle -> selectInt, pc=0x105 next cycle, intAck pulse, inHandler=1; target dropped.
- In handler: second intReq -> stays pending. Then resultValid+retReq with insResult=0x40 -> pc=0x40, RUN; next cycle the interrupt is taken.
- excReq code 0x03 in RUN -> pc=0x203, inHandler=1. Second excReq in handler -> halted=1, pcValid=0, stays until reset.
- PC_ALIGN_CHECK_EN: targetValid with insTarget=0x42 -> selectExc, pc=0x201. Without the macro -> pc=0x42.
- pc=0xFFFF_FFFC, moved -> pc=0x0000_0000.
